// File: rtl/unsign_decimal_serializer_pkg.sv
// Shared definitions for the unsigned binary-to-decimal serializer:
// FSM encodings, the number base and the digit-count formula.
`ifndef UNSIGN_DECIMAL_SERIALIZER_PKG_SV
`define UNSIGN_DECIMAL_SERIALIZER_PKG_SV

// Upper bound on decimal digits for a w-bit word (77/256 approximates log10(2)).
`define UDS_DIGIT_COUNT(w) (((w) * 77 + 255) / 256)

package unsign_decimal_serializer_pkg;

    typedef enum logic [1:0] {
        SER_IDLE   = 2'd0,
        SER_DIVIDE = 2'd1,
        SER_EMIT   = 2'd2
    } serState_e;

    localparam int DECIMAL_BASE = 10;

    function automatic int digitCount(input int width);
        return `UDS_DIGIT_COUNT(width);
    endfunction

endpackage

`endif

// File: rtl/unsign_decimal_serializer_divider.sv
// Combinational restoring divider: one quotient bit per dividend bit,
// with a remainder no wider than the divisor.
module UnsignDividerComb #(
    parameter int DIVIDEND_WIDTH = 8,
    parameter int DIVISOR_WIDTH  = 4
) (
    input  logic                      Clk,
    input  logic [DIVIDEND_WIDTH-1:0] Dividend,
    input  logic [DIVISOR_WIDTH-1:0]  Divisor,
    output logic [DIVIDEND_WIDTH-1:0] Quotient,
    output logic [DIVISOR_WIDTH-1:0]  Remainder
);

    // The clock port exists so pipelined variants can drop in; this one is purely combinational.
    logic unusedClk;
    assign unusedClk = Clk;

    always_comb begin
        logic [DIVISOR_WIDTH:0] partial;
        partial  = '0;
        Quotient = '0;
        for (int i = DIVIDEND_WIDTH - 1; i >= 0; i--) begin
            partial = {partial[DIVISOR_WIDTH-1:0], Dividend[i]};
            if (partial >= {1'b0, Divisor}) begin
                partial     = partial - {1'b0, Divisor};
                Quotient[i] = 1'b1;
            end
        end
        Remainder = partial[DIVISOR_WIDTH-1:0];
    end

endmodule

// File: rtl/unsign_decimal_serializer.sv
// Converts an unsigned word to decimal by repeated division by ten, then
// streams the buffered digits most-significant first over valid/ready.
module unsign_decimal_serializer
    import unsign_decimal_serializer_pkg::*;
#(
    parameter int INPUT_BIT_WIDTH = 8
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [INPUT_BIT_WIDTH-1:0] InValue,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [3:0]                 OutDigit,
    output logic                       OutLast,
    output logic                       Busy
);

    localparam int DIGITS = digitCount(INPUT_BIT_WIDTH);
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam logic [3:0] BASE_DIGIT = 4'(DECIMAL_BASE);

    serState_e                  state_q, state_d;
    logic [INPUT_BIT_WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [3:0]                 stack_q [DIGITS];
    logic [3:0]                 stack_d [DIGITS];
    logic                       outValid_q, outValid_d;
    logic [3:0]                 outDigit_q, outDigit_d;
    logic                       outLast_q, outLast_d;

    logic [INPUT_BIT_WIDTH-1:0] quotient;
    logic [3:0]                 remainder;

    UnsignDividerComb #(
        .DIVIDEND_WIDTH(INPUT_BIT_WIDTH),
        .DIVISOR_WIDTH (4)
    ) divider (
        .Clk      (Clk),
        .Dividend (work_q),
        .Divisor  (BASE_DIGIT),
        .Quotient (quotient),
        .Remainder(remainder)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= SER_IDLE;
            work_q     <= '0;
            count_q    <= '0;
            outValid_q <= 1'b0;
            outDigit_q <= '0;
            outLast_q  <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            count_q    <= count_d;
            outValid_q <= outValid_d;
            outDigit_q <= outDigit_d;
            outLast_q  <= outLast_d;
            stack_q    <= stack_d;
        end
    end

    // Output registers are loaded one step ahead so the digit at the top of the stack is already on OutDigit when EMIT begins.
    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        count_d    = count_q;
        stack_d    = stack_q;
        outValid_d = outValid_q;
        outDigit_d = outDigit_q;
        outLast_d  = outLast_q;

        case (state_q)
            SER_IDLE: begin
                if (InValid) begin
                    work_d  = InValue;
                    count_d = '0;
                    state_d = SER_DIVIDE;
                end
            end

            SER_DIVIDE: begin
                stack_d[count_q] = remainder;
                count_d          = count_q + CNT_W'(1);
                work_d           = quotient;
                if (quotient == '0) begin
                    state_d    = SER_EMIT;
                    outValid_d = 1'b1;
                    outDigit_d = remainder;
                    outLast_d  = (count_q == '0);
                end
            end

            SER_EMIT: begin
                if (OutReady) begin
                    if (count_q == CNT_W'(1)) begin
                        state_d    = SER_IDLE;
                        count_d    = '0;
                        outValid_d = 1'b0;
                        outDigit_d = '0;
                        outLast_d  = 1'b0;
                    end else begin
                        count_d    = count_q - CNT_W'(1);
                        outDigit_d = stack_q[count_q - CNT_W'(2)];
                        outLast_d  = (count_q == CNT_W'(2));
                    end
                end
            end

            default: begin
                state_d = SER_IDLE;
            end
        endcase
    end

    assign InReady  = (state_q == SER_IDLE);
    assign Busy     = (state_q != SER_IDLE);
    assign OutValid = outValid_q;
    assign OutDigit = outDigit_q;
    assign OutLast  = outLast_q;

endmodule

// File: tb/tb_unsign_decimal_serializer.sv
// Directed bench for the decimal serializer: an 8-bit and a 16-bit instance
// share one clock and reset and are exercised with hand-computed digit streams.
module tb_unsign_decimal_serializer;

    logic clock = 1'b0;
    logic reset;

    logic       inValid8, inReady8, outValid8, outReady8, outLast8, busy8;
    logic [7:0] inValue8;
    logic [3:0] outDigit8;

    logic        inValid16, inReady16, outValid16, outReady16, outLast16, busy16;
    logic [15:0] inValue16;
    logic [3:0]  outDigit16;

    int checks   = 0;
    int failures = 0;

    logic [3:0] expQ [$];

    always #5 clock = ~clock;

    unsign_decimal_serializer #(.INPUT_BIT_WIDTH(8)) dut8 (
        .Clk(clock), .Rst(reset),
        .InValid(inValid8), .InReady(inReady8), .InValue(inValue8),
        .OutValid(outValid8), .OutReady(outReady8), .OutDigit(outDigit8),
        .OutLast(outLast8), .Busy(busy8)
    );

    unsign_decimal_serializer #(.INPUT_BIT_WIDTH(16)) dut16 (
        .Clk(clock), .Rst(reset),
        .InValid(inValid16), .InReady(inReady16), .InValue(inValue16),
        .OutValid(outValid16), .OutReady(outReady16), .OutDigit(outDigit16),
        .OutLast(outLast16), .Busy(busy16)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Offer a value, wait (bounded) for acceptance, and leave the bench in the cycle after the accept edge.
    task automatic applyStimulus(input bit wide, input int value);
        int guard = 0;
        if (wide) begin
            inValue16 = value[15:0];
            inValid16 = 1'b1;
        end else begin
            inValue8 = value[7:0];
            inValid8 = 1'b1;
        end
        while (!(wide ? inReady16 : inReady8) && guard < 50) begin
            step();
            guard++;
        end
        checkOutput("accept ready", wide ? inReady16 : inReady8, 1);
        step();
        inValid8  = 1'b0;
        inValid16 = 1'b0;
    endtask

    // Check latency, then every cycle of the digit stream against expQ, advancing only on handshakes.
    task automatic expectStream(input string tag, input bit wide, input int startCycle,
                                input int expLatency, input logic [3:0] pattern);
        int cyc   = startCycle;
        int idx   = 0;
        int guard = 0;
        while (!(wide ? outValid16 : outValid8) && cyc < 60) begin
            step();
            cyc++;
        end
        checkOutput({tag, " latency"}, cyc, expLatency);
        while (idx < expQ.size() && guard < 100) begin
            outReady8  = pattern[guard % 4];
            outReady16 = pattern[guard % 4];
            checkOutput({tag, " valid"}, wide ? outValid16 : outValid8, 1);
            checkOutput({tag, " digit"}, wide ? outDigit16 : outDigit8, expQ[idx]);
            checkOutput({tag, " last"}, wide ? outLast16 : outLast8, (idx == expQ.size() - 1) ? 1 : 0);
            if (outReady8) idx++;
            step();
            guard++;
        end
        checkOutput({tag, " count"}, idx, expQ.size());
        checkOutput({tag, " idle valid"}, wide ? outValid16 : outValid8, 0);
        checkOutput({tag, " idle ready"}, wide ? inReady16 : inReady8, 1);
        outReady8  = 1'b1;
        outReady16 = 1'b1;
    endtask

    initial begin
        int w;
        reset      = 1'b1;
        inValid8   = 1'b0;
        inValue8   = '0;
        outReady8  = 1'b1;
        inValid16  = 1'b0;
        inValue16  = '0;
        outReady16 = 1'b1;
        step();
        step();

        checkOutput("reset inReady", inReady8, 1);
        checkOutput("reset busy", busy8, 0);
        checkOutput("reset outValid", outValid8, 0);
        checkOutput("reset outDigit", outDigit8, 0);
        checkOutput("reset outLast", outLast8, 0);
        checkOutput("reset16 inReady", inReady16, 1);
        checkOutput("reset16 outValid", outValid16, 0);
        reset = 1'b0;
        step();

        $display("[TB] 255 with no backpressure");
        expQ = '{4'd2, 4'd5, 4'd5};
        applyStimulus(1'b0, 255);
        checkOutput("t255 busy", busy8, 1);
        expectStream("t255", 1'b0, 1, 4, 4'b1111);

        $display("[TB] zero produces one digit");
        expQ = '{4'd0};
        applyStimulus(1'b0, 0);
        expectStream("t0", 1'b0, 1, 2, 4'b1111);

        $display("[TB] 100 under stalls");
        expQ = '{4'd1, 4'd0, 4'd0};
        applyStimulus(1'b0, 100);
        expectStream("t100", 1'b0, 1, 4, 4'b1001);

        $display("[TB] 16-bit back-to-back with held InValid");
        inValue16 = 16'd65535;
        inValid16 = 1'b1;
        checkOutput("t65535 accept ready", inReady16, 1);
        step();
        inValue16 = 16'd7;
        expQ = '{4'd6, 4'd5, 4'd5, 4'd3, 4'd5};
        expectStream("t65535", 1'b1, 1, 6, 4'b1111);
        step();
        checkOutput("t7 accepted busy", busy16, 1);
        checkOutput("t7 accepted inReady", inReady16, 0);
        expQ = '{4'd7};
        expectStream("t7", 1'b1, 1, 2, 4'b1111);
        inValid16 = 1'b0;

        $display("[TB] reset during emit");
        applyStimulus(1'b0, 255);
        w = 0;
        while (!outValid8 && w < 20) begin
            step();
            w++;
        end
        checkOutput("trst first digit", outDigit8, 2);
        step();
        checkOutput("trst second digit", outDigit8, 5);
        reset = 1'b1;
        #1;
        checkOutput("trst async valid", outValid8, 0);
        checkOutput("trst async ready", inReady8, 1);
        #1;
        reset = 1'b0;
        step();
        checkOutput("trst after valid", outValid8, 0);
        checkOutput("trst after ready", inReady8, 1);
        checkOutput("trst after busy", busy8, 0);
        expQ = '{4'd4, 4'd2};
        applyStimulus(1'b0, 42);
        expectStream("t42", 1'b0, 1, 3, 4'b1111);

        $display("[TB] InValid pulse while busy");
        expQ = '{4'd2, 4'd0, 4'd7};
        applyStimulus(1'b0, 207);
        checkOutput("t207 busy", busy8, 1);
        inValue8 = 8'd9;
        inValid8 = 1'b1;
        step();
        inValid8 = 1'b0;
        expectStream("t207", 1'b0, 2, 4, 4'b1111);
        step();
        step();
        checkOutput("t207 no phantom valid", outValid8, 0);
        checkOutput("t207 no phantom busy", busy8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
